hazard_unit: RTL and testbench
==============================

Name: hazard_unit

Overview:
Parametrised hazard and forwarding unit for the N-stage RV32I pipeline, replacing the per-decode forward/stall flags.
- Keeps a shadow scoreboard of in-flight destination registers, one entry per stage beyond ID.
- Drives prioritised forward-mux selects, load-use stalls and multi-cycle flush after a branch/jump redirect.
- Sits beside the controller; its outputs feed the EX operand muxes and the IF/ID pipeline enables.

Parameters:
NUM_STAGES, 2, tracked stages beyond ID (entry 1 = EX, entry k = k stages past ID); range 1..6
LOAD_LATENCY, 1, load in entry k is forwardable only when k > LOAD_LATENCY
FLUSH_CYCLES, 1, cycles flush_o stays high per redirect; range 1..4
REG_AW, 5, register address width

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
id_valid  in  1  ID holds a real instruction
id_rs1  in  REG_AW  ID source 1
id_rs2  in  REG_AW  ID source 2
id_rs1_used  in  1  instruction reads rs1
id_rs2_used  in  1  instruction reads rs2
id_rd  in  REG_AW  ID destination
id_reg_we  in  1  instruction writes rd
id_is_load  in  1  instruction is a load
ex_redirect  in  1  EX resolved taken branch/JAL/JALR this cycle
stall_o  out  1  hold PC and IF/ID; bubble into EX
flush_o  out  1  kill instruction(s) in IF/ID
fwd_sel_a  out  FWD_W  operand A source: 0 = regfile, k = entry k result
fwd_sel_b  out  FWD_W  same for operand B
FWD_W = $clog2(NUM_STAGES+1)

Behaviour:
- Clock and reset: one clock clk; reset rst_n is asynchronous, active-low.
- Reset: all entries invalid, flush counter 0, stall_o=0, flush_o=0, fwd_sel_a=fwd_sel_b=0. Reset mid-flush or mid-stall discards all state immediately.
- Entry contents: {valid, rd, we, is_load}.
- Entry update, every clock:
  - entry[k] <= entry[k-1] for k >= 2.
  - entry[1] <= ID instruction, valid = id_valid & ~stall_o & ~flush_o.
  - During a stall or flush a bubble (valid=0) enters entry 1; older entries always advance.
- Match rule: entry k matches rsX when valid & we & rd==rsX & rsX!=0 & rsX_used.
  - rs==x0 never forwards and never stalls.
- Forward select (combinational): fwd_sel = the lowest matching k (youngest producer wins), else 0.
- Load-use:
  - If the lowest match for rs1 or rs2 is a load with k <= LOAD_LATENCY, stall_o=1 and that operand's fwd_sel=0.
  - The stall lasts until the load passes entry LOAD_LATENCY, i.e. LOAD_LATENCY-k+1 cycles.
  - An older non-load match never overrides a younger load match.
- Flush:
  - flush_o = ex_redirect | (flush_cnt != 0).
  - On ex_redirect, flush_cnt loads FLUSH_CYCLES-1; otherwise it decrements to 0 and saturates.
  - A redirect while flush_cnt != 0 reloads the counter.
- Simultaneous stall and redirect: redirect wins; stall_o forced 0 while flush_o=1 (the stalling instruction is being killed).
- id_valid=0: stall_o=0, fwd_sel=0, a bubble enters entry 1.
- Latency: all outputs are combinational from current entries and ID inputs; no extra cycle.

Optional Feature:
HAZARD_PERF_EN
- Defined: adds outputs perf_stall_cnt[31:0] and perf_flush_cnt[31:0].
  - Each increments on cycles where stall_o / flush_o is 1.
  - Both wrap at 2^32 and clear on reset.
- Undefined: the ports and counters are absent; no other behaviour changes.

Decomposition:
- hazard_pkg:
  - typedef struct packed hz_entry_t {valid, rd, we, is_load}.
  - localparam FWD_REGFILE=0.
  - function fwd_width(n).
- Sub-module hazard_fwd_match: combinational priority encoder over the entry array for one source register, returning {hit_sel, load_block}. Instantiated twice (rs1, rs2).

Test Plan:
- Back-to-back dependence: add x5 then add x6,x5,x1 -> cycle 2 fwd_sel_a=1, stall_o=0; NUM_STAGES=2, gap of one instruction -> fwd_sel_a=2.
- Load-use: lw x7 then add x8,x7,x7 -> stall_o=1 exactly 1 cycle; next cycle fwd_sel_a=fwd_sel_b=2, entry 1 bubble.
- Youngest wins: add x3 (entry 2) and lw x3 (entry 1) both pending, ID reads x3 -> stall_o=1, not fwd_sel=2.
- x0 / unused: rd=x0 producer, or rs2_used=0 with matching rs2 -> fwd_sel=0, no stall.
- Redirect with FLUSH_CYCLES=2 -> flush_o high 2 cycles, entry 1 bubbles; second ex_redirect in cycle 2 -> flush_o extends to 3 cycles total; redirect during load-use stall -> stall_o=0.
- Async reset asserted mid-flush -> flush_o, stall_o, fwd_sel drop to 0 without a clock edge; with HAZARD_PERF_EN, counters read 0.

Source files
------------

// File: rtl/hazard_pkg.sv
// rtl/hazard_pkg.sv - shared types and helpers for the hazard/forwarding unit
package hazard_pkg;

  // Entry rd field is sized for the widest supported register file; narrower
  // REG_AW values are zero-extended on entry.
  localparam int HZ_RD_W     = 8;
  localparam int FWD_REGFILE = 0;

  typedef struct packed {
    logic               valid;
    logic [HZ_RD_W-1:0] rd;
    logic               we;
    logic               is_load;
  } hz_entry_t;

  function automatic int fwd_width(input int n);
    return (n < 1) ? 1 : $clog2(n + 1);
  endfunction

endpackage

// File: rtl/hazard_fwd_match.sv
// rtl/hazard_fwd_match.sv - priority match of one source register against the scoreboard
module hazard_fwd_match
  import hazard_pkg::*;
#(
  parameter int  NUM_STAGES   = 2,
  parameter int  LOAD_LATENCY = 1,
  localparam int FWD_W        = fwd_width(NUM_STAGES)
) (
  input  hz_entry_t [NUM_STAGES-1:0] entries,
  input  logic [HZ_RD_W-1:0]         rs,
  input  logic                       rs_used,
  output logic [FWD_W-1:0]           hit_sel,
  output logic                       load_block
);

  // Scan oldest to youngest so the youngest producer's assignment lands last.
  always_comb begin
    hit_sel    = FWD_W'(FWD_REGFILE);
    load_block = 1'b0;
    for (int k = NUM_STAGES; k >= 1; k--) begin
      if (entries[k-1].valid && entries[k-1].we && (entries[k-1].rd == rs) &&
          (rs != '0) && rs_used) begin
        hit_sel    = FWD_W'(k);
        load_block = entries[k-1].is_load && (k <= LOAD_LATENCY);
      end
    end
  end

endmodule

// File: rtl/hazard_unit.sv
// rtl/hazard_unit.sv - scoreboard-based forwarding, load-use stall and redirect flush
// Optional perf counters enabled by defining HAZARD_PERF_EN.
module hazard_unit
  import hazard_pkg::*;
#(
  parameter int  NUM_STAGES   = 2,
  parameter int  LOAD_LATENCY = 1,
  parameter int  FLUSH_CYCLES = 1,
  parameter int  REG_AW       = 5,
  localparam int FWD_W        = fwd_width(NUM_STAGES)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              id_valid,
  input  logic [REG_AW-1:0] id_rs1,
  input  logic [REG_AW-1:0] id_rs2,
  input  logic              id_rs1_used,
  input  logic              id_rs2_used,
  input  logic [REG_AW-1:0] id_rd,
  input  logic              id_reg_we,
  input  logic              id_is_load,
  input  logic              ex_redirect,
  output logic              stall_o,
  output logic              flush_o,
  output logic [FWD_W-1:0]  fwd_sel_a,
  output logic [FWD_W-1:0]  fwd_sel_b
`ifdef HAZARD_PERF_EN
  ,
  output logic [31:0]       perf_stall_cnt,
  output logic [31:0]       perf_flush_cnt
`endif
);

  hz_entry_t [NUM_STAGES-1:0] entries;
  hz_entry_t                  id_entry;
  logic [2:0]                 flush_cnt;
  logic [FWD_W-1:0]           hit_a, hit_b;
  logic                       blk_a, blk_b;

  hazard_fwd_match #(
    .NUM_STAGES   (NUM_STAGES),
    .LOAD_LATENCY (LOAD_LATENCY)
  ) u_match_a (
    .entries    (entries),
    .rs         (HZ_RD_W'(id_rs1)),
    .rs_used    (id_valid & id_rs1_used),
    .hit_sel    (hit_a),
    .load_block (blk_a)
  );

  hazard_fwd_match #(
    .NUM_STAGES   (NUM_STAGES),
    .LOAD_LATENCY (LOAD_LATENCY)
  ) u_match_b (
    .entries    (entries),
    .rs         (HZ_RD_W'(id_rs2)),
    .rs_used    (id_valid & id_rs2_used),
    .hit_sel    (hit_b),
    .load_block (blk_b)
  );

  // A redirect kills the stalling instruction, so flush overrides stall.
  always_comb begin
    flush_o   = ex_redirect | (flush_cnt != 3'd0);
    stall_o   = (blk_a | blk_b) & ~flush_o;
    fwd_sel_a = blk_a ? FWD_W'(FWD_REGFILE) : hit_a;
    fwd_sel_b = blk_b ? FWD_W'(FWD_REGFILE) : hit_b;
  end

  always_comb begin
    id_entry.valid   = id_valid & ~stall_o & ~flush_o;
    id_entry.rd      = HZ_RD_W'(id_rd);
    id_entry.we      = id_reg_we;
    id_entry.is_load = id_is_load;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      entries <= '0;
    end else begin
      entries[0] <= id_entry;
      for (int k = 1; k < NUM_STAGES; k++) begin
        entries[k] <= entries[k-1];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      flush_cnt <= 3'd0;
    end else if (ex_redirect) begin
      flush_cnt <= 3'(FLUSH_CYCLES - 1);
    end else if (flush_cnt != 3'd0) begin
      flush_cnt <= flush_cnt - 3'd1;
    end
  end

`ifdef HAZARD_PERF_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_stall_cnt <= 32'd0;
      perf_flush_cnt <= 32'd0;
    end else begin
      if (stall_o) perf_stall_cnt <= perf_stall_cnt + 32'd1;
      if (flush_o) perf_flush_cnt <= perf_flush_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_hazard_unit.sv
// tb/tb_hazard_unit.sv - directed self-checking bench for hazard_unit
module tb_hazard_unit;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       id_valid;
  logic [4:0] id_rs1, id_rs2, id_rd;
  logic       id_rs1_used, id_rs2_used, id_reg_we, id_is_load;
  logic       ex_redirect;
  logic       stall_o, flush_o;
  logic [1:0] fwd_sel_a, fwd_sel_b;
`ifdef HAZARD_PERF_EN
  logic [31:0] perf_stall_cnt, perf_flush_cnt;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  hazard_unit #(
    .NUM_STAGES   (2),
    .LOAD_LATENCY (1),
    .FLUSH_CYCLES (2),
    .REG_AW       (5)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .id_valid    (id_valid),
    .id_rs1      (id_rs1),
    .id_rs2      (id_rs2),
    .id_rs1_used (id_rs1_used),
    .id_rs2_used (id_rs2_used),
    .id_rd       (id_rd),
    .id_reg_we   (id_reg_we),
    .id_is_load  (id_is_load),
    .ex_redirect (ex_redirect),
    .stall_o     (stall_o),
    .flush_o     (flush_o),
    .fwd_sel_a   (fwd_sel_a),
    .fwd_sel_b   (fwd_sel_b)
`ifdef HAZARD_PERF_EN
    ,
    .perf_stall_cnt (perf_stall_cnt),
    .perf_flush_cnt (perf_flush_cnt)
`endif
  );

  task automatic set_id(input logic v, input logic [4:0] rs1, input logic [4:0] rs2,
                        input logic u1, input logic u2, input logic [4:0] rd,
                        input logic we, input logic ld);
    id_valid = v; id_rs1 = rs1; id_rs2 = rs2; id_rs1_used = u1; id_rs2_used = u2;
    id_rd = rd; id_reg_we = we; id_is_load = ld;
  endtask

  task automatic clear_id();
    set_id(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0);
  endtask

  // Advance to 1ns after the next rising edge; inputs are then driven and
  // outputs checked 1ns later, well away from any edge.
  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    clear_id();
    ex_redirect = 1'b0;
    repeat (3) next_cycle();
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    ex_redirect = 1'b0;
    clear_id();
    next_cycle();
    next_cycle();
    checks++;
    if (stall_o !== 1'b0 || flush_o !== 1'b0 || fwd_sel_a !== 2'd0 || fwd_sel_b !== 2'd0) begin
      errors++;
      $display("FAIL reset_outputs stall=%b flush=%b a=%0d b=%0d required 0 0 0 0",
               stall_o, flush_o, fwd_sel_a, fwd_sel_b);
    end
`ifdef HAZARD_PERF_EN
    checks++;
    if (perf_stall_cnt !== 32'd0 || perf_flush_cnt !== 32'd0) begin
      errors++;
      $display("FAIL reset_perf stall_cnt=%0d flush_cnt=%0d required 0 0", perf_stall_cnt, perf_flush_cnt);
    end
`endif
    rst_n = 1'b1;
  endtask

  task automatic test_back_to_back();
    drain();
    set_id(1'b1, 5'd1, 5'd2, 1'b1, 1'b1, 5'd5, 1'b1, 1'b0);
    #1;
    checks++;
    if (fwd_sel_a !== 2'd0 || stall_o !== 1'b0) begin
      errors++;
      $display("FAIL b2b_first a=%0d stall=%b required 0 0", fwd_sel_a, stall_o);
    end
    next_cycle();
    set_id(1'b1, 5'd5, 5'd1, 1'b1, 1'b1, 5'd6, 1'b1, 1'b0);
    #1;
    checks++;
    if (fwd_sel_a !== 2'd1 || fwd_sel_b !== 2'd0 || stall_o !== 1'b0) begin
      errors++;
      $display("FAIL b2b_dep a=%0d b=%0d stall=%b required 1 0 0", fwd_sel_a, fwd_sel_b, stall_o);
    end
    next_cycle();
    set_id(1'b1, 5'd5, 5'd6, 1'b1, 1'b1, 5'd9, 1'b1, 1'b0);
    #1;
    checks++;
    if (fwd_sel_a !== 2'd2 || fwd_sel_b !== 2'd1 || stall_o !== 1'b0) begin
      errors++;
      $display("FAIL b2b_gap a=%0d b=%0d stall=%b required 2 1 0", fwd_sel_a, fwd_sel_b, stall_o);
    end
  endtask

  task automatic test_load_use();
    drain();
    set_id(1'b1, 5'd1, 5'd0, 1'b1, 1'b0, 5'd7, 1'b1, 1'b1);
    next_cycle();
    set_id(1'b1, 5'd7, 5'd7, 1'b1, 1'b1, 5'd8, 1'b1, 1'b0);
    #1;
    checks++;
    if (stall_o !== 1'b1 || fwd_sel_a !== 2'd0 || fwd_sel_b !== 2'd0) begin
      errors++;
      $display("FAIL load_use_stall stall=%b a=%0d b=%0d required 1 0 0", stall_o, fwd_sel_a, fwd_sel_b);
    end
    next_cycle();
    #1;
    checks++;
    if (stall_o !== 1'b0 || fwd_sel_a !== 2'd2 || fwd_sel_b !== 2'd2) begin
      errors++;
      $display("FAIL load_use_release stall=%b a=%0d b=%0d required 0 2 2", stall_o, fwd_sel_a, fwd_sel_b);
    end
    next_cycle();
    set_id(1'b1, 5'd8, 5'd7, 1'b1, 1'b1, 5'd9, 1'b1, 1'b0);
    #1;
    checks++;
    if (fwd_sel_a !== 2'd1 || fwd_sel_b !== 2'd0 || stall_o !== 1'b0) begin
      errors++;
      $display("FAIL load_use_bubble a=%0d b=%0d stall=%b required 1 0 0", fwd_sel_a, fwd_sel_b, stall_o);
    end
  endtask

  task automatic test_youngest_wins();
    drain();
    set_id(1'b1, 5'd1, 5'd2, 1'b1, 1'b1, 5'd3, 1'b1, 1'b0);
    next_cycle();
    set_id(1'b1, 5'd1, 5'd0, 1'b1, 1'b0, 5'd3, 1'b1, 1'b1);
    next_cycle();
    set_id(1'b1, 5'd3, 5'd0, 1'b1, 1'b1, 5'd4, 1'b1, 1'b0);
    #1;
    checks++;
    if (stall_o !== 1'b1 || fwd_sel_a !== 2'd0) begin
      errors++;
      $display("FAIL youngest_load stall=%b a=%0d required 1 0", stall_o, fwd_sel_a);
    end
    next_cycle();
    #1;
    checks++;
    if (stall_o !== 1'b0 || fwd_sel_a !== 2'd2) begin
      errors++;
      $display("FAIL youngest_release stall=%b a=%0d required 0 2", stall_o, fwd_sel_a);
    end
  endtask

  task automatic test_x0_unused();
    drain();
    set_id(1'b1, 5'd1, 5'd2, 1'b1, 1'b1, 5'd0, 1'b1, 1'b0);
    next_cycle();
    set_id(1'b1, 5'd0, 5'd0, 1'b1, 1'b1, 5'd10, 1'b1, 1'b0);
    #1;
    checks++;
    if (fwd_sel_a !== 2'd0 || fwd_sel_b !== 2'd0 || stall_o !== 1'b0) begin
      errors++;
      $display("FAIL x0_src a=%0d b=%0d stall=%b required 0 0 0", fwd_sel_a, fwd_sel_b, stall_o);
    end
    next_cycle();
    set_id(1'b1, 5'd1, 5'd0, 1'b1, 1'b0, 5'd9, 1'b1, 1'b1);
    next_cycle();
    set_id(1'b1, 5'd1, 5'd9, 1'b1, 1'b0, 5'd11, 1'b1, 1'b0);
    #1;
    checks++;
    if (fwd_sel_b !== 2'd0 || stall_o !== 1'b0) begin
      errors++;
      $display("FAIL rs2_unused b=%0d stall=%b required 0 0", fwd_sel_b, stall_o);
    end
    set_id(1'b0, 5'd9, 5'd9, 1'b1, 1'b1, 5'd11, 1'b1, 1'b0);
    #1;
    checks++;
    if (fwd_sel_a !== 2'd0 || fwd_sel_b !== 2'd0 || stall_o !== 1'b0) begin
      errors++;
      $display("FAIL id_invalid a=%0d b=%0d stall=%b required 0 0 0", fwd_sel_a, fwd_sel_b, stall_o);
    end
  endtask

  task automatic test_redirect();
    int high;
    drain();
    set_id(1'b1, 5'd1, 5'd2, 1'b1, 1'b1, 5'd10, 1'b1, 1'b0);
    ex_redirect = 1'b1;
    #1;
    high = int'(flush_o);
    next_cycle();
    ex_redirect = 1'b0;
    set_id(1'b1, 5'd10, 5'd0, 1'b1, 1'b0, 5'd11, 1'b1, 1'b0);
    #1;
    high += int'(flush_o);
    checks++;
    if (fwd_sel_a !== 2'd0) begin
      errors++;
      $display("FAIL flush_bubble a=%0d required 0", fwd_sel_a);
    end
    next_cycle();
    clear_id();
    #1;
    checks++;
    if (high !== 2 || flush_o !== 1'b0) begin
      errors++;
      $display("FAIL flush_len2 high_cycles=%0d flush_after=%b required 2 0", high, flush_o);
    end

    drain();
    ex_redirect = 1'b1;
    #1;
    high = int'(flush_o);
    next_cycle();
    #1;
    high += int'(flush_o);
    next_cycle();
    ex_redirect = 1'b0;
    #1;
    high += int'(flush_o);
    next_cycle();
    #1;
    checks++;
    if (high !== 3 || flush_o !== 1'b0) begin
      errors++;
      $display("FAIL flush_extend high_cycles=%0d flush_after=%b required 3 0", high, flush_o);
    end

    drain();
    set_id(1'b1, 5'd1, 5'd0, 1'b1, 1'b0, 5'd7, 1'b1, 1'b1);
    next_cycle();
    set_id(1'b1, 5'd7, 5'd0, 1'b1, 1'b0, 5'd8, 1'b1, 1'b0);
    ex_redirect = 1'b1;
    #1;
    checks++;
    if (stall_o !== 1'b0 || flush_o !== 1'b1) begin
      errors++;
      $display("FAIL redirect_over_stall stall=%b flush=%b required 0 1", stall_o, flush_o);
    end
    ex_redirect = 1'b0;
  endtask

  task automatic test_async_reset();
    drain();
    set_id(1'b1, 5'd1, 5'd2, 1'b1, 1'b1, 5'd12, 1'b1, 1'b0);
    next_cycle();
    set_id(1'b1, 5'd1, 5'd0, 1'b1, 1'b0, 5'd13, 1'b1, 1'b1);
    ex_redirect = 1'b1;
    next_cycle();
    ex_redirect = 1'b0;
    set_id(1'b1, 5'd12, 5'd0, 1'b1, 1'b0, 5'd14, 1'b1, 1'b0);
    #1;
    checks++;
    if (flush_o !== 1'b1 || fwd_sel_a !== 2'd2) begin
      errors++;
      $display("FAIL pre_reset flush=%b a=%0d required 1 2", flush_o, fwd_sel_a);
    end
    #1;
    rst_n = 1'b0;
    #1;
    checks++;
    if (flush_o !== 1'b0 || stall_o !== 1'b0 || fwd_sel_a !== 2'd0 || fwd_sel_b !== 2'd0) begin
      errors++;
      $display("FAIL async_reset flush=%b stall=%b a=%0d b=%0d required 0 0 0 0",
               flush_o, stall_o, fwd_sel_a, fwd_sel_b);
    end
`ifdef HAZARD_PERF_EN
    checks++;
    if (perf_stall_cnt !== 32'd0 || perf_flush_cnt !== 32'd0) begin
      errors++;
      $display("FAIL async_reset_perf stall_cnt=%0d flush_cnt=%0d required 0 0", perf_stall_cnt, perf_flush_cnt);
    end
`endif
    next_cycle();
    rst_n = 1'b1;
    clear_id();
`ifdef HAZARD_PERF_EN
    ex_redirect = 1'b1;
    next_cycle();
    ex_redirect = 1'b0;
    next_cycle();
    next_cycle();
    checks++;
    if (perf_flush_cnt !== 32'd2 || perf_stall_cnt !== 32'd0) begin
      errors++;
      $display("FAIL perf_count flush_cnt=%0d stall_cnt=%0d required 2 0", perf_flush_cnt, perf_stall_cnt);
    end
`endif
  endtask

  initial begin
    test_reset();
    test_back_to_back();
    test_load_use();
    test_youngest_wins();
    test_x0_unused();
    test_redirect();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
